// File: rtl/trng_core_param.sv
// TRNG core with NUM_OSC oscillator cells, an XOR combiner, optional von Neumann
// debiasing, a repetition-count health test and a WORD_W-bit valid/ready output.

module trng_core_param #(
    parameter int NUM_OSC    = 4,
    parameter int WORD_W     = 32,
    parameter int WARMUP_CYC = 256,
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_LIMIT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vn_en,
    input  logic              test_mode,
    input  logic              test_bit,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail,
    output logic              busy
);
    localparam int WC_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int DV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam int RC_W = $clog2(RCT_LIMIT + 1);
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_CYC - 1);
    localparam logic [DV_W-1:0] DIV_LAST  = DV_W'(SAMPLE_DIV - 1);
    localparam logic [BC_W-1:0] WORD_LAST = BC_W'(WORD_W - 1);
    localparam logic [RC_W-1:0] RCT_TRIP  = RC_W'(RCT_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

    state_t             r_state;
    logic               r_osc_t;
    logic               r_vn_en;
    logic               r_test_mode;
    logic [WC_W-1:0]    r_warm_cnt;
    logic [DV_W-1:0]    r_div_cnt;
    logic [RC_W-1:0]    r_rct_cnt;
    logic               r_prev_raw;
    logic               r_vn_have;
    logic               r_vn_first;
    logic [WORD_W-1:0]  r_acc;
    logic [BC_W-1:0]    r_bit_cnt;
    logic               r_pending;
    logic [NUM_OSC-1:0] r_sync1;
    logic [NUM_OSC-1:0] r_sync2;

    logic [NUM_OSC-1:0] w_osc;
    logic               w_osc_i1;
    logic               w_osc_i2;
    logic               w_strobe;
    logic               w_raw;
    logic [RC_W-1:0]    w_rct_next;
    logic               w_rct_trip;
    logic               w_cond_vld;
    logic               w_cond_bit;
    logic [WORD_W-1:0]  w_acc_next;
    logic               w_word_done;
    logic               w_out_free;
    logic               w_hs;

    assign w_osc_i1 = 1'b1;
    assign w_osc_i2 = 1'b0;

    // Behavioural oscillator cells: each free-runs while T=1 and freezes while T=0.
    for (genvar g = 0; g < NUM_OSC; g++) begin : g_osc_cell
        logic [15:0] r_lfsr;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_lfsr <= 16'hACE1 ^ 16'(g * 4919);
            else if (r_osc_t)
                r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]
                                         ^ (w_osc_i1 & ~w_osc_i2)};
        end
        assign w_osc[g] = r_lfsr[15];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_osc;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_strobe    = (r_state == S_RUN) && (r_div_cnt == DIV_LAST);
        w_raw       = r_test_mode ? test_bit : ^r_sync2;
        if ((r_rct_cnt == '0) || (w_raw != r_prev_raw))
            w_rct_next = RC_W'(1);
        else
            w_rct_next = r_rct_cnt + 1'b1;
        w_rct_trip  = w_strobe && (w_rct_next == RCT_TRIP);
        // With debiasing, a bit emerges only on the second sample of an unequal pair.
        w_cond_vld  = w_strobe && (!r_vn_en || (r_vn_have && (r_vn_first != w_raw)));
        w_cond_bit  = r_vn_en ? r_vn_first : w_raw;
        w_acc_next  = {r_acc[WORD_W-2:0], w_cond_bit};
        w_word_done = w_cond_vld && !r_pending && (r_bit_cnt == WORD_LAST);
        w_hs        = rnd_valid && rnd_ready;
        w_out_free  = !rnd_valid || rnd_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_osc_t     <= 1'b0;
            r_vn_en     <= 1'b0;
            r_test_mode <= 1'b0;
            r_warm_cnt  <= '0;
            r_div_cnt   <= '0;
            r_rct_cnt   <= '0;
            r_prev_raw  <= 1'b0;
            r_vn_have   <= 1'b0;
            r_vn_first  <= 1'b0;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_pending   <= 1'b0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
            busy        <= 1'b0;
        end else if (!enable) begin
            r_state     <= S_IDLE;
            r_osc_t     <= 1'b0;
            r_warm_cnt  <= '0;
            r_div_cnt   <= '0;
            r_rct_cnt   <= '0;
            r_vn_have   <= 1'b0;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_pending   <= 1'b0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vn_en     <= vn_en;
                    r_test_mode <= test_mode;
                    r_warm_cnt  <= '0;
                    r_osc_t     <= 1'b1;
                    busy        <= 1'b1;
                    r_state     <= S_WARMUP;
                end
                S_WARMUP: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_div_cnt <= '0;
                        r_rct_cnt <= '0;
                        r_vn_have <= 1'b0;
                        r_state   <= S_RUN;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
                    if (w_strobe) begin
                        r_rct_cnt  <= w_rct_next;
                        r_prev_raw <= w_raw;
                        if (r_vn_en) begin
                            r_vn_have <= !r_vn_have;
                            if (!r_vn_have)
                                r_vn_first <= w_raw;
                        end
                    end
                    if (w_rct_trip) begin
                        r_state     <= S_FAIL;
                        r_osc_t     <= 1'b0;
                        busy        <= 1'b0;
                        health_fail <= 1'b1;
                        rnd_valid   <= 1'b0;
                        r_acc       <= '0;
                        r_bit_cnt   <= '0;
                        r_pending   <= 1'b0;
                    end else if (w_word_done && w_out_free) begin
                        rnd_data  <= w_acc_next;
                        rnd_valid <= 1'b1;
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                    end else if (r_pending && w_out_free) begin
                        rnd_data  <= r_acc;
                        rnd_valid <= 1'b1;
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                        r_pending <= 1'b0;
                    end else begin
                        if (w_hs)
                            rnd_valid <= 1'b0;
                        // A finished word parks in the accumulator until the output frees.
                        if (w_word_done) begin
                            r_acc     <= w_acc_next;
                            r_pending <= 1'b1;
                        end else if (w_cond_vld && !r_pending) begin
                            r_acc     <= w_acc_next;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    r_osc_t <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
